// File: rtl/cus19_isa_pkg.sv
// Shared ISA definitions for the 19-bit instruction encoder and decoder:
// opcodes, per-format field positions and loader FSM states.
package cus19_isa_pkg;

    localparam int INSTR_W = 19;

    localparam logic [2:0] OP_R = 3'b000;
    localparam logic [2:0] OP_M = 3'b001;
    localparam logic [2:0] OP_J = 3'b010;
    localparam logic [2:0] OP_B = 3'b011;
    localparam logic [2:0] OP_S = 3'b100;

    localparam int OPC_W     = 3;
    localparam int REG_W     = 4;
    localparam int FUNCT_LSB = 3;

    localparam int R_FUNCT_W = 4;
    localparam int R_RS2_LSB = 7;
    localparam int R_RS1_LSB = 11;
    localparam int R_RD_LSB  = 15;

    localparam int M_RS1_LSB = 4;
    localparam int M_IMM_LSB = 8;
    localparam int M_IMM_W   = 11;

    localparam int J_FUNCT_W = 2;
    localparam int J_IMM_LSB = 5;
    localparam int J_IMM_W   = 11;

    // B and S share the rs2/rs1 placement; only B carries an immediate.
    localparam int BS_RS2_LSB = 4;
    localparam int BS_RS1_LSB = 8;
    localparam int B_IMM_LSB  = 12;
    localparam int B_IMM_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= OP_S;
    endfunction

endpackage

// File: rtl/cus19_enc_fifo.sv
// Synchronous FIFO holding encoded words; head is presented from registered
// storage and reads as zero while empty.
module cus19_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/cus19_instr_encoder.sv
// Program loader: encodes field sets into 19-bit instructions and streams them
// to instruction memory. Define CUS19_ENC_RANGE_CHECK_EN to add err_range.
module cus19_instr_encoder
    import cus19_isa_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [2:0]          in_opcode,
    input  logic [3:0]          in_funct,
    input  logic [3:0]          in_rs1,
    input  logic [3:0]          in_rs2,
    input  logic [3:0]          in_rd,
    input  logic [10:0]         in_imm,
    output logic                imem_we,
    input  logic                imem_ready,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                done,
    output logic                err_illegal,
    output logic [ADDR_W-1:0]   wr_count
`ifdef CUS19_ENC_RANGE_CHECK_EN
    ,output logic               err_range
`endif
);
    enc_state_e         r_state;
    enc_state_e         w_state_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_wr_count;
    logic               r_err_illegal;
    logic [INSTR_W-1:0] w_word;
    logic [INSTR_W-1:0] w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_accept;
    logic               w_legal;
    logic               w_range_bad;
    logic               w_push;
    logic               w_pop;
    logic               w_session_start;

    assign w_session_start = (r_state == ST_IDLE) && start;
    assign w_legal         = is_legal_op(in_opcode);
    assign w_accept        = in_valid && in_ready;
    assign w_push          = w_accept && w_legal && !w_range_bad;
    assign w_pop           = imem_we && imem_ready;

    assign in_ready    = (r_state == ST_LOAD) && !w_fifo_full;
    assign imem_we     = ((r_state == ST_LOAD) || (r_state == ST_DRAIN)) && !w_fifo_empty;
    assign imem_wdata  = w_head;
    assign imem_addr   = r_addr;
    assign done        = (r_state == ST_DONE);
    assign err_illegal = r_err_illegal;
    assign wr_count    = r_wr_count;

    always_comb begin
        w_word = '0;
        w_word[OPC_W-1:0] = in_opcode;
        case (in_opcode)
            OP_R: begin
                w_word[FUNCT_LSB +: R_FUNCT_W] = in_funct;
                w_word[R_RS2_LSB +: REG_W]     = in_rs2;
                w_word[R_RS1_LSB +: REG_W]     = in_rs1;
                w_word[R_RD_LSB  +: REG_W]     = in_rd;
            end
            OP_M: begin
                w_word[FUNCT_LSB]              = in_funct[0];
                w_word[M_RS1_LSB +: REG_W]     = in_rs1;
                w_word[M_IMM_LSB +: M_IMM_W]   = in_imm[M_IMM_W-1:0];
            end
            OP_J: begin
                w_word[FUNCT_LSB +: J_FUNCT_W] = in_funct[J_FUNCT_W-1:0];
                w_word[J_IMM_LSB +: J_IMM_W]   = in_imm[J_IMM_W-1:0];
            end
            OP_B: begin
                w_word[FUNCT_LSB]              = in_funct[0];
                w_word[BS_RS2_LSB +: REG_W]    = in_rs2;
                w_word[BS_RS1_LSB +: REG_W]    = in_rs1;
                w_word[B_IMM_LSB +: B_IMM_W]   = in_imm[B_IMM_W-1:0];
            end
            OP_S: begin
                w_word[FUNCT_LSB]              = in_funct[0];
                w_word[BS_RS2_LSB +: REG_W]    = in_rs2;
                w_word[BS_RS1_LSB +: REG_W]    = in_rs1;
            end
            default: ;
        endcase
    end

`ifdef CUS19_ENC_RANGE_CHECK_EN
    logic r_err_range;

    // Formats without an immediate (R, S) treat any nonzero imm bit as excess.
    always_comb begin
        w_range_bad = 1'b0;
        case (in_opcode)
            OP_R:    w_range_bad = |in_imm;
            OP_M:    w_range_bad = |in_funct[3:1];
            OP_J:    w_range_bad = |in_funct[3:2];
            OP_B:    w_range_bad = (|in_funct[3:1]) || (|in_imm[10:7]);
            OP_S:    w_range_bad = (|in_funct[3:1]) || (|in_imm);
            default: w_range_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_range <= 1'b0;
        end else if (w_session_start) begin
            r_err_range <= 1'b0;
        end else if (w_accept && w_legal && w_range_bad) begin
            r_err_range <= 1'b1;
        end
    end

    assign err_range = r_err_range;
`else
    assign w_range_bad = 1'b0;
`endif

    cus19_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_session_start),
        .push  (w_push),
        .wdata (w_word),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = ST_LOAD;
            ST_LOAD:  if (w_accept && in_last) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= ADDR_W'(BASE_ADDR);
            r_wr_count    <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_session_start) begin
                r_addr        <= ADDR_W'(BASE_ADDR);
                r_wr_count    <= '0;
                r_err_illegal <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_wr_count <= r_wr_count + ADDR_W'(1);
                end
                if (w_accept && !w_legal) r_err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cus19_instr_encoder.sv
// Bench for cus19_instr_encoder: two instances (default and a 3-bit address
// space starting at 6) share stimulus; a field-level model predicts each write.
module tb_cus19_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last, imem_ready;
    logic [2:0]  in_opcode;
    logic [3:0]  in_funct, in_rs1, in_rs2, in_rd;
    logic [10:0] in_imm;

    logic        in_ready, imem_we, done, err_illegal;
    logic [7:0]  imem_addr, wr_count;
    logic [18:0] imem_wdata;

    logic        in_ready_2, imem_we_2, done_2, err_illegal_2;
    logic [2:0]  imem_addr_2, wr_count_2;
    logic [18:0] imem_wdata_2;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q1[$];
    logic [18:0] exp_q2[$];
    int exp_addr1, exp_addr2, exp_cnt, exp_err;
    bit stream_on;

    always #5 clk = ~clk;

    cus19_instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_opcode(in_opcode), .in_funct(in_funct), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .done(done), .err_illegal(err_illegal), .wr_count(wr_count)
    );

    cus19_instr_encoder #(.DEPTH(4), .ADDR_W(3), .BASE_ADDR(6)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_2),
        .in_last(in_last), .in_opcode(in_opcode), .in_funct(in_funct), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm), .imem_we(imem_we_2),
        .imem_ready(imem_ready), .imem_addr(imem_addr_2), .imem_wdata(imem_wdata_2),
        .done(done_2), .err_illegal(err_illegal_2), .wr_count(wr_count_2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction word built from field values by weighted sums of the format layout.
    function automatic logic [18:0] ref_enc(input int op, input int funct, input int rs1,
                                            input int rs2, input int rd, input int imm);
        int v;
        case (op)
            0:       v = funct * 8 + rs2 * 128 + rs1 * 2048 + rd * 32768;
            1:       v = 1 + (funct % 2) * 8 + rs1 * 16 + imm * 256;
            2:       v = 2 + (funct % 4) * 8 + imm * 32;
            3:       v = 3 + (funct % 2) * 8 + rs2 * 16 + rs1 * 256 + (imm % 128) * 4096;
            default: v = 4 + (funct % 2) * 8 + rs2 * 16 + rs1 * 256;
        endcase
        return 19'(v);
    endfunction

    // Transaction monitor: accepted beats feed the model, writes are checked against it.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (in_valid && in_ready) begin
                if (in_opcode <= 3'd4) begin
                    exp_q1.push_back(ref_enc(int'(in_opcode), int'(in_funct), int'(in_rs1),
                                             int'(in_rs2), int'(in_rd), int'(in_imm)));
                    exp_cnt++;
                end else begin
                    exp_err = 1;
                end
            end
            if (in_valid && in_ready_2 && in_opcode <= 3'd4)
                exp_q2.push_back(ref_enc(int'(in_opcode), int'(in_funct), int'(in_rs1),
                                         int'(in_rs2), int'(in_rd), int'(in_imm)));
            if (imem_we && imem_ready) begin
                chk("wr1_expected", 32'(exp_q1.size() > 0), 32'(1));
                if (exp_q1.size() > 0) chk("wr1_data", 32'(imem_wdata), 32'(exp_q1.pop_front()));
                chk("wr1_addr", 32'(imem_addr), 32'(exp_addr1 % 256));
                $display("write dut1 addr=%02h data=%05h", imem_addr, imem_wdata);
                exp_addr1++;
            end
            if (imem_we_2 && imem_ready) begin
                chk("wr2_expected", 32'(exp_q2.size() > 0), 32'(1));
                if (exp_q2.size() > 0) chk("wr2_data", 32'(imem_wdata_2), 32'(exp_q2.pop_front()));
                chk("wr2_addr", 32'(imem_addr_2), 32'(exp_addr2 % 8));
                exp_addr2++;
            end
        end
    end

    task automatic model_clear();
        exp_q1.delete();
        exp_q2.delete();
        exp_addr1 = 0;
        exp_addr2 = 6;
        exp_cnt   = 0;
        exp_err   = 0;
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] funct, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [3:0] rd, input logic [10:0] imm,
                        input logic last);
        int n;
        @(posedge clk); #1;
        in_opcode = op; in_funct = funct; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 200);
        if (in_ready !== 1'b1) chk("in_ready_timeout", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 300);
        chk({name, "_done"}, 32'(done), 32'(1));
        chk({name, "_wr_count"}, 32'(wr_count), 32'(exp_cnt % 256));
        chk({name, "_wr_count2"}, 32'(wr_count_2), 32'(exp_cnt % 8));
        chk({name, "_err_illegal"}, 32'(err_illegal), 32'(exp_err));
        chk({name, "_drained"}, 32'(exp_q1.size() + exp_q2.size()), 32'(0));
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'(0));
        $display("session %s complete wr_count=%0d err_illegal=%0b", name, wr_count, err_illegal);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1;
        in_opcode = '0; in_funct = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        stream_on = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_we", 32'(imem_we), 32'(0));
        chk("rst_addr", 32'(imem_addr), 32'(0));
        chk("rst_addr2", 32'(imem_addr_2), 32'(6));
        chk("rst_wdata", 32'(imem_wdata), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err_illegal), 32'(0));
        chk("rst_wr_count", 32'(wr_count), 32'(0));

        // Single R-format instruction.
        do_start();
        send(3'd0, 4'hA, 4'h4, 4'h3, 4'hF, 11'h0, 1'b1);
        wait_done("r_single");

        // One of each remaining format; wraps the 3-bit address instance.
        do_start();
        send(3'd1, 4'h1, 4'h5, 4'h0, 4'h0, 11'h555, 1'b0);
        send(3'd2, 4'h2, 4'h0, 4'h0, 4'h0, 11'h2AA, 1'b0);
        send(3'd3, 4'h1, 4'hA, 4'h6, 4'h0, 11'h007, 1'b0);
        send(3'd4, 4'h1, 4'hC, 4'h2, 4'h0, 11'h000, 1'b1);
        wait_done("formats");

        // Back-pressure: FIFO fills, outputs hold, then drains in order.
        imem_ready = 1'b0;
        do_start();
        for (int i = 0; i < 4; i++)
            send(3'($urandom_range(0, 4)), 4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), 11'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'(0));
            chk("hold_we", 32'(imem_we), 32'(1));
            chk("hold_addr", 32'(imem_addr), 32'(exp_addr1 % 256));
            chk("hold_data", 32'(imem_wdata), 32'(exp_q1[0]));
        end
        @(posedge clk); #1 imem_ready = 1'b1;
        send(3'd0, 4'h5, 4'h6, 4'h7, 4'h8, 11'h0, 1'b0);
        send(3'd3, 4'h0, 4'h1, 4'h2, 4'h0, 11'h7F, 1'b1);
        wait_done("backpressure");

        // Illegal opcode mid-session is consumed but never written.
        do_start();
        send(3'd1, 4'h0, 4'h3, 4'h0, 4'h0, 11'h123, 1'b0);
        send(3'd6, 4'hF, 4'hF, 4'hF, 4'hF, 11'h7FF, 1'b0);
        send(3'd2, 4'h3, 4'h0, 4'h0, 4'h0, 11'h001, 1'b1);
        wait_done("illegal_mid");

        // A new session clears the sticky error; B imm above 7 bits truncates; illegal last beat.
        do_start();
        @(negedge clk);
        chk("start_clears_err", 32'(err_illegal), 32'(0));
        chk("start_clears_count", 32'(wr_count), 32'(0));
        send(3'd3, 4'h1, 4'hA, 4'h6, 4'h0, 11'h080, 1'b0);
        send(3'd7, 4'h0, 4'h0, 4'h0, 4'h0, 11'h000, 1'b1);
        wait_done("illegal_last");

        // Random session with random opcodes and random write back-pressure.
        do_start();
        stream_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 14; i++)
                    send(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                         4'($urandom), 11'($urandom), 1'(i == 13));
                stream_on = 1'b0;
            end
            begin
                while (stream_on) begin
                    @(posedge clk); #1;
                    imem_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        imem_ready = 1'b1;
        wait_done("random");

        // Reset while draining abandons the session.
        imem_ready = 1'b0;
        do_start();
        send(3'd0, 4'h1, 4'h2, 4'h3, 4'h4, 11'h0, 1'b0);
        send(3'd4, 4'h1, 4'h2, 4'h3, 4'h0, 11'h0, 1'b0);
        send(3'd2, 4'h1, 4'h0, 4'h0, 4'h0, 11'h3, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("mid_rst_we", 32'(imem_we), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
        chk("mid_rst_addr", 32'(imem_addr), 32'(0));
        chk("mid_rst_addr2", 32'(imem_addr_2), 32'(6));
        chk("mid_rst_wdata", 32'(imem_wdata), 32'(0));
        chk("mid_rst_wr_count", 32'(wr_count), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'(0));
            chk("post_rst_no_we", 32'(imem_we), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cus19_instr_encoder.md
Name: cus19_instr_encoder

Overview:
- Inverse of the 19-bit instruction decoder: packs opcode, funct, register and immediate fields into a 19-bit instruction word.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a write port with an auto-incrementing address.
- Used as the on-chip program loader between the host/boot interface and the CPU instruction memory.

Parameters:
- DEPTH, 4, encoded-word FIFO depth (power of 2, ≥2)
- ADDR_W, 8, instruction-memory address width
- BASE_ADDR, 0, first write address after start

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept a field set
- in_last  in  1  marks final instruction of session
- in_opcode  in  3  opcode
- in_funct  in  4  funct (format-dependent width used)
- in_rs1  in  4  source reg 1
- in_rs2  in  4  source reg 2
- in_rd  in  4  destination reg
- in_imm  in  11  immediate/address
- imem_we  out  1  instruction-memory write strobe
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  19  encoded instruction
- done  out  1  one-cycle pulse, session complete
- err_illegal  out  1  sticky: illegal opcode seen this session
- wr_count  out  ADDR_W  words written this session

Behaviour:
- Encoding (bit 0 = LSB, all unused bits zero):
  - R (000): [2:0]op, [6:3]funct, [10:7]rs2, [14:11]rs1, [18:15]rd.
  - M (001): [3]funct[0], [7:4]rs1, [18:8]imm[10:0].
  - J (010): [4:3]funct[1:0], [15:5]imm[10:0], [18:16]=0.
  - B (011): [3]funct[0], [7:4]rs2, [11:8]rs1, [18:12]imm[6:0].
  - S (100): [3]funct[0], [7:4]rs2, [11:8]rs1, [18:12]=0.
  - Field bits beyond format width ignored.
- Illegal opcodes (101/110/111):
  - Handshake completes; the word is not pushed.
  - err_illegal set; it clears only on start or reset.
- FSM states IDLE, LOAD, DRAIN, DONE:
  - IDLE → LOAD on start. Entry actions: addr ← BASE_ADDR, wr_count ← 0, err_illegal ← 0, FIFO flushed.
  - LOAD → DRAIN on an accepted beat with in_last=1, including an illegal last beat.
  - DRAIN → DONE when FIFO is empty and no write is pending.
  - DONE → IDLE unconditionally; done=1 for exactly that cycle.
  - start outside IDLE is ignored.
- Input handshake:
  - in_ready = (state==LOAD) && !fifo_full.
  - Transfer occurs on in_valid && in_ready.
  - When full, push is refused even if a pop occurs in the same cycle.
- Write side:
  - imem_we = (state∈{LOAD,DRAIN}) && !fifo_empty; imem_wdata = FIFO head.
  - Pop occurs on imem_we && imem_ready. On pop, imem_addr and wr_count increment.
  - imem_addr wraps modulo 2^ADDR_W.
  - imem_ready low holds imem_we, imem_addr and imem_wdata stable.
- Latency: an accepted word reaches imem_wdata no earlier than the next cycle (registered FIFO).
- Push and pop in the same cycle are legal when the FIFO is not full.
- Reset, or reset mid-session:
  - state = IDLE; FIFO empty.
  - imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - in_ready = 0, done = 0, err_illegal = 0, wr_count = 0.
  - Partial sessions are abandoned.

Optional Feature:
- Macro: CUS19_ENC_RANGE_CHECK_EN.
- Defined:
  - Adds output err_range (1, sticky, cleared like err_illegal).
  - A beat whose in_imm has nonzero bits above the format's immediate width (B: imm[10:7]) or whose funct has nonzero bits above the format funct width is dropped (not pushed) and sets err_range.
- Undefined:
  - No err_range port.
  - Excess bits are silently truncated.

Decomposition:
- Package cus19_isa_pkg holds:
  - opcode localparams (OP_R=000, OP_M=001, OP_J=010, OP_B=011, OP_S=100);
  - field bit-position/width constants per format;
  - FSM state encodings.
- The decoder shares the same package.
- Sub-module cus19_enc_fifo (sync FIFO, DEPTH×19, full/empty flags, async active-high reset).
- Encode logic is combinational inside the top.

Test Plan:
- start; R op=000 funct=A rs2=3 rs1=4 rd=F, in_last=1, imem_ready=1 → single write addr 0x00, data 19'h7A1D0, then done pulse; wr_count=1.
- M(funct1, rs1=5, imm=0x555), J(funct2, imm=0x2AA), B(funct1, rs2=6, rs1=A, imm=7), S(funct1, rs2=2, rs1=C, last) → data 0x55559, 0x05552, 0x07A6B, 0x00C2C at addr 0..3.
- imem_ready=0 for 10 cycles while streaming 6 words → in_ready drops after 4 accepted; outputs held stable; all 6 written in order after release.
- opcode=110 mid-session → not written, err_illegal=1, wr_count excludes it; next start clears err_illegal.
- ADDR_W=3, BASE_ADDR=6, 4 words → addresses 6,7,0,1; rst asserted mid-DRAIN → immediate IDLE, imem_we=0, no done pulse.
- Range check: B imm=0x80 → with macro: dropped, err_range=1; without macro: written as 0x00A6B (rs2=6, rs1=A, funct1).
